// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mnemonic codes, opcode/funct values and field widths.
// The instruction encoder and the control unit both import this package.
package mips_pkg;

  // Instruction format field widths
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int OP_W     = 5;

  // Symbolic mnemonic codes carried on the request bus
  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_NOR   = 5'd5,
    OP_ADDU  = 5'd6,
    OP_SUBU  = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_SRL   = 5'd10,
    OP_SLL   = 5'd11,
    OP_ADDI  = 5'd12,
    OP_ADDIU = 5'd13,
    OP_ANDI  = 5'd14,
    OP_ORI   = 5'd15,
    OP_XORI  = 5'd16,
    OP_SLTI  = 5'd17,
    OP_SLTIU = 5'd18,
    OP_LW    = 5'd19,
    OP_SW    = 5'd20,
    OP_BEQ   = 5'd21,
    OP_BNE   = 5'd22,
    OP_J     = 5'd23,
    OP_JAL   = 5'd24
  } op_e;

  // Instruction format selected for a mnemonic; FMT_ILL marks unused codes
  typedef enum logic [1:0] {
    FMT_ILL = 2'd0,
    FMT_R   = 2'd1,
    FMT_I   = 2'd2,
    FMT_J   = 2'd3
  } fmt_e;

  // Encoder session states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

  // Primary opcodes
  localparam logic [OPCODE_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OPC_ADDIU = 6'b001001;
  localparam logic [OPCODE_W-1:0] OPC_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OPC_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OPC_XORI  = 6'b001110;
  localparam logic [OPCODE_W-1:0] OPC_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OPC_SLTIU = 6'b001011;
  localparam logic [OPCODE_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OPC_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OPC_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OPC_JAL   = 6'b000011;

  // R-type funct values
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'b101011;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'b000000;

  // Shift instructions take their amount from shamt and ignore rs
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic instruction request bus: valid/ready handshake plus the fields
// needed to build one MIPS word. The master drives requests, the encoder is the slave.
interface instr_encoder_if;
  import mips_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_op;
  logic [REG_W-1:0]    req_rs;
  logic [REG_W-1:0]    req_rt;
  logic [REG_W-1:0]    req_rd;
  logic [SHAMT_W-1:0]  req_shamt;
  logic [IMM_W-1:0]    req_imm;
  logic [TARGET_W-1:0] req_target;
  logic                req_last;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
           req_imm, req_target, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
           req_imm, req_target, req_last,
    output req_ready
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: turns a mnemonic code and its fields into a 32-bit
// MIPS word, flagging codes that have no encoding.
module instr_pack
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  output logic [INSTR_W-1:0]  word,
  output logic                illegal
);

  fmt_e                fmt;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;

  // Map each mnemonic to its format and its opcode or funct value
  always_comb begin
    fmt    = FMT_ILL;
    opcode = OPC_RTYPE;
    funct  = FN_SLL;
    case (op)
      OP_ADD:   begin fmt = FMT_R; funct  = FN_ADD;    end
      OP_SUB:   begin fmt = FMT_R; funct  = FN_SUB;    end
      OP_AND:   begin fmt = FMT_R; funct  = FN_AND;    end
      OP_OR:    begin fmt = FMT_R; funct  = FN_OR;     end
      OP_XOR:   begin fmt = FMT_R; funct  = FN_XOR;    end
      OP_NOR:   begin fmt = FMT_R; funct  = FN_NOR;    end
      OP_ADDU:  begin fmt = FMT_R; funct  = FN_ADDU;   end
      OP_SUBU:  begin fmt = FMT_R; funct  = FN_SUBU;   end
      OP_SLT:   begin fmt = FMT_R; funct  = FN_SLT;    end
      OP_SLTU:  begin fmt = FMT_R; funct  = FN_SLTU;   end
      OP_SRL:   begin fmt = FMT_R; funct  = FN_SRL;    end
      OP_SLL:   begin fmt = FMT_R; funct  = FN_SLL;    end
      OP_ADDI:  begin fmt = FMT_I; opcode = OPC_ADDI;  end
      OP_ADDIU: begin fmt = FMT_I; opcode = OPC_ADDIU; end
      OP_ANDI:  begin fmt = FMT_I; opcode = OPC_ANDI;  end
      OP_ORI:   begin fmt = FMT_I; opcode = OPC_ORI;   end
      OP_XORI:  begin fmt = FMT_I; opcode = OPC_XORI;  end
      OP_SLTI:  begin fmt = FMT_I; opcode = OPC_SLTI;  end
      OP_SLTIU: begin fmt = FMT_I; opcode = OPC_SLTIU; end
      OP_LW:    begin fmt = FMT_I; opcode = OPC_LW;    end
      OP_SW:    begin fmt = FMT_I; opcode = OPC_SW;    end
      OP_BEQ:   begin fmt = FMT_I; opcode = OPC_BEQ;   end
      OP_BNE:   begin fmt = FMT_I; opcode = OPC_BNE;   end
      OP_J:     begin fmt = FMT_J; opcode = OPC_J;     end
      OP_JAL:   begin fmt = FMT_J; opcode = OPC_JAL;   end
      default:  fmt = FMT_ILL;
    endcase
  end

  // Assemble the word; shifts zero rs, every other R-type zeroes shamt
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        if (is_shift(op)) begin
          word = {OPC_RTYPE, {REG_W{1'b0}}, rt, rd, shamt, funct};
        end else begin
          word = {OPC_RTYPE, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
        end
      end
      FMT_I:   word = {opcode, rs, rt, imm};
      FMT_J:   word = {opcode, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-loading encoder: accepts symbolic instruction requests, packs them
// into MIPS words and writes them to instruction memory from address 0 upward.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  instr_encoder_if.slave     req,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_full,
  output logic [ADDR_W:0]    instr_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  enc_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [INSTR_W-1:0]  word_q, word_d;
  logic                last_q, last_d;
  logic                err_illegal_q, err_illegal_d;
  logic                err_full_q, err_full_d;

  logic [INSTR_W-1:0]  pack_word;
  logic                pack_illegal;
  logic                handshake;
  logic                at_end;

  instr_pack u_pack (
    .op      (req.req_op),
    .rs      (req.req_rs),
    .rt      (req.req_rt),
    .rd      (req.req_rd),
    .shamt   (req.req_shamt),
    .imm     (req.req_imm),
    .target  (req.req_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign handshake = (state_q == ST_ACCEPT) && req.req_valid;
  assign at_end    = (ptr_q == LAST_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: illegal requests stay in ACCEPT unless they close the session
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        if (handshake) begin
          if (!pack_illegal)        state_d = ST_WRITE;
          else if (req.req_last)    state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (last_q || at_end) state_d = ST_DONE;
        else                  state_d = ST_ACCEPT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs from state; the write strobe drops as soon as reset is asserted
  always_comb begin
    req.req_ready = (state_q == ST_ACCEPT);
    imem_we       = (state_q == ST_WRITE) && rst_n;
    imem_addr     = (state_q == ST_WRITE) ? ptr_q  : '0;
    imem_wdata    = (state_q == ST_WRITE) ? word_q : '0;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    err_illegal   = err_illegal_q;
    err_full      = err_full_q;
    instr_count   = count_q;
  end

  // Datapath: session clear on start, capture on handshake, advance on write
  always_comb begin
    ptr_d         = ptr_q;
    count_d       = count_q;
    word_d        = word_q;
    last_d        = last_q;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d         = '0;
          count_d       = '0;
          err_illegal_d = 1'b0;
          err_full_d    = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (handshake) begin
          if (pack_illegal) begin
            err_illegal_d = 1'b1;
          end else begin
            word_d = pack_word;
            last_d = req.req_last;
          end
        end
      end
      ST_WRITE: begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (!last_q && at_end) err_full_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      count_q       <= '0;
      word_q        <= '0;
      last_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      word_q        <= word_d;
      last_q        <= last_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word memory so the fill
// boundary is reachable; expected words are hand-encoded constants.
module tb_instr_encoder;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err_illegal;
  logic          err_full;
  logic [AW:0]   instr_count;

  int check_count = 0;
  int fail_count  = 0;
  int wr_count    = 0;

  instr_encoder_if ifc ();

  instr_encoder #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .req         (ifc.slave),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .err_full    (err_full),
    .instr_count (instr_count)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Count memory writes as a memory would see them at the clock edge
  always @(posedge clk) begin
    if (imem_we) wr_count <= wr_count + 1;
  end

  // Hard stop if the run never reaches its summary
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm,
                               input logic [25:0] target, input logic last, input int max_wait,
                               output logic accepted);
    ifc.req_op     = op;
    ifc.req_rs     = rs;
    ifc.req_rt     = rt;
    ifc.req_rd     = rd;
    ifc.req_shamt  = shamt;
    ifc.req_imm    = imm;
    ifc.req_target = target;
    ifc.req_last   = last;
    ifc.req_valid  = 1'b1;
    accepted       = 1'b0;
    for (int i = 0; i < max_wait && !accepted; i++) begin
      if (ifc.req_ready) accepted = 1'b1;
      nextCycle();
    end
    ifc.req_valid = 1'b0;
  endtask

  task automatic sendReq(input string tag, input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm,
                         input logic [25:0] target, input logic last);
    logic accepted;
    applyStimulus(op, rs, rt, rd, shamt, imm, target, last, 8, accepted);
    checkOutput({tag, "_hs"}, 32'(accepted), 32'd1);
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [31:0] word);
    checkOutput({tag, "_we"},    32'(imem_we),       32'd1);
    checkOutput({tag, "_addr"},  32'(imem_addr),     addr);
    checkOutput({tag, "_data"},  imem_wdata,         word);
    checkOutput({tag, "_ready"}, 32'(ifc.req_ready), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 32'(ifc.req_ready), 32'd0);
    checkOutput({tag, "_we"},    32'(imem_we),       32'd0);
    checkOutput({tag, "_addr"},  32'(imem_addr),     32'd0);
    checkOutput({tag, "_data"},  imem_wdata,         32'd0);
    checkOutput({tag, "_busy"},  32'(busy),          32'd0);
    checkOutput({tag, "_done"},  32'(done),          32'd0);
    checkOutput({tag, "_eill"},  32'(err_illegal),   32'd0);
    checkOutput({tag, "_efull"}, 32'(err_full),      32'd0);
    checkOutput({tag, "_count"}, 32'(instr_count),   32'd0);
  endtask

  task automatic startSession();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int   wc;
    logic acc;
    ifc.req_valid  = 1'b0;
    ifc.req_op     = '0;
    ifc.req_rs     = '0;
    ifc.req_rt     = '0;
    ifc.req_rd     = '0;
    ifc.req_shamt  = '0;
    ifc.req_imm    = '0;
    ifc.req_target = '0;
    ifc.req_last   = 1'b0;

    nextCycle();
    nextCycle();
    checkAllZero("reset");
    rst_n = 1'b1;
    nextCycle();

    // Single ADD with last
    startSession();
    checkOutput("s1_busy",  32'(busy),          32'd1);
    checkOutput("s1_ready", 32'(ifc.req_ready), 32'd1);
    sendReq("s1_add", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    checkWrite("s1_add", 32'd0, 32'h00221820);
    nextCycle();
    checkOutput("s1_done",  32'(done),        32'd1);
    checkOutput("s1_we0",   32'(imem_we),     32'd0);
    checkOutput("s1_count", 32'(instr_count), 32'd1);
    nextCycle();
    checkOutput("s1_done_pulse", 32'(done),        32'd0);
    checkOutput("s1_idle_busy",  32'(busy),        32'd0);
    checkOutput("s1_hold_count", 32'(instr_count), 32'd1);
    checkOutput("s1_wr_total",   32'(wr_count),    32'd1);

    // Stream ADDI, LW, J(last)
    startSession();
    checkOutput("s2_count_clr", 32'(instr_count), 32'd0);
    sendReq("s2_addi", 5'd12, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'h0, 1'b0);
    checkWrite("s2_addi", 32'd0, 32'h20080005);
    nextCycle();
    checkOutput("s2_ready_back", 32'(ifc.req_ready), 32'd1);
    sendReq("s2_lw", 5'd19, 5'd8, 5'd9, 5'd0, 5'd0, 16'd4, 26'h0, 1'b0);
    checkWrite("s2_lw", 32'd1, 32'h8D090004);
    sendReq("s2_j", 5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
    checkWrite("s2_j", 32'd2, 32'h08000010);
    nextCycle();
    checkOutput("s2_done",  32'(done),        32'd1);
    checkOutput("s2_count", 32'(instr_count), 32'd3);
    nextCycle();

    // Shift forcing and shamt masking
    startSession();
    sendReq("s3_sll", 5'd11, 5'd7, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 1'b0);
    checkWrite("s3_sll", 32'd0, 32'h000220C0);
    sendReq("s3_add0", 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 16'h0, 26'h0, 1'b1);
    checkWrite("s3_add0", 32'd1, 32'h00000020);
    nextCycle();
    checkOutput("s3_count", 32'(instr_count), 32'd2);
    nextCycle();

    // Illegal op then ADD(last)
    startSession();
    wc = wr_count;
    sendReq("s4_ill", 5'd27, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
    checkOutput("s4_ill_we",    32'(imem_we),       32'd0);
    checkOutput("s4_ill_flag",  32'(err_illegal),   32'd1);
    checkOutput("s4_ill_ready", 32'(ifc.req_ready), 32'd1);
    sendReq("s4_add", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    checkWrite("s4_add", 32'd0, 32'h00221820);
    nextCycle();
    checkOutput("s4_done",   32'(done),        32'd1);
    checkOutput("s4_count",  32'(instr_count), 32'd1);
    checkOutput("s4_writes", 32'(wr_count - wc), 32'd1);
    nextCycle();
    checkOutput("s4_eill_hold", 32'(err_illegal), 32'd1);

    // Illegal op carrying last closes the session with no write
    startSession();
    checkOutput("s5_eill_clr", 32'(err_illegal), 32'd0);
    sendReq("s5_ill_last", 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    checkOutput("s5_done",  32'(done),        32'd1);
    checkOutput("s5_we",    32'(imem_we),     32'd0);
    checkOutput("s5_count", 32'(instr_count), 32'd0);
    checkOutput("s5_eill",  32'(err_illegal), 32'd1);
    nextCycle();

    // Fill the memory without last
    startSession();
    wc = wr_count;
    for (int i = 0; i < 4; i++) begin
      sendReq($sformatf("s6_ori%0d", i), 5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 26'h0, 1'b0);
      checkWrite($sformatf("s6_ori%0d", i), 32'(i), 32'h34220000 + 32'(i));
    end
    nextCycle();
    checkOutput("s6_done",  32'(done),        32'd1);
    checkOutput("s6_efull", 32'(err_full),    32'd1);
    checkOutput("s6_count", 32'(instr_count), 32'd4);
    applyStimulus(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'd9, 26'h0, 1'b0, 4, acc);
    checkOutput("s6_5th_rejected", 32'(acc),           32'd0);
    checkOutput("s6_writes",       32'(wr_count - wc), 32'd4);
    checkOutput("s6_efull_hold",   32'(err_full),      32'd1);
    checkOutput("s6_idle_busy",    32'(busy),          32'd0);

    // Fill boundary with last on the final address
    startSession();
    checkOutput("s7_efull_clr", 32'(err_full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sendReq($sformatf("s7_xori%0d", i), 5'd16, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0100 + 16'(i), 26'h0, i == 3);
      checkWrite($sformatf("s7_xori%0d", i), 32'(i), 32'h38640100 + 32'(i));
    end
    nextCycle();
    checkOutput("s7_done",  32'(done),        32'd1);
    checkOutput("s7_efull", 32'(err_full),    32'd0);
    checkOutput("s7_count", 32'(instr_count), 32'd4);
    nextCycle();

    // Reset during the second write of a session
    startSession();
    sendReq("s8_add", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    checkWrite("s8_add", 32'd0, 32'h00221820);
    sendReq("s8_sub", 5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
    checkWrite("s8_sub", 32'd1, 32'h00853022);
    rst_n = 1'b0;
    #1;
    checkOutput("s8_we_abort", 32'(imem_we), 32'd0);
    wc = wr_count;
    nextCycle();
    checkOutput("s8_no_write", 32'(wr_count - wc), 32'd0);
    checkAllZero("s8_rst");
    rst_n = 1'b1;
    nextCycle();
    startSession();
    sendReq("s8_again", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    checkWrite("s8_again", 32'd0, 32'h00221820);
    nextCycle();
    checkOutput("s8_done",  32'(done),        32'd1);
    checkOutput("s8_count", 32'(instr_count), 32'd1);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-loading encoder for the MIPS core: the inverse of the instruction decoder. It accepts symbolic instruction requests (mnemonic code plus register, immediate and target fields) over a valid/ready handshake. It packs each request into a 32-bit MIPS word and writes the words sequentially into instruction memory from address 0. It is used by the bench and the boot path to build programs that the control unit then decodes.

## Interface
- `IMEM_DEPTH`, default 256: instruction-memory depth in words; minimum 2.
- `ADDR_W`, default 8: imem word-address width; `2**ADDR_W >= IMEM_DEPTH`.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a load session; ignored unless IDLE.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  encoder can accept a request.
- `req_op`  in  5  mnemonic code (see Operation).
- `req_rs`, `req_rt`, `req_rd`, `req_shamt`  in  5 each  register and shift fields.
- `req_imm`  in  16  I-type immediate.
- `req_target`  in  26  J-type target.
- `req_last`  in  1  final instruction of the session.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.
- `err_illegal`  out  1  sticky: illegal `req_op` seen.
- `err_full`  out  1  sticky: memory filled before `req_last`.
- `instr_count`  out  ADDR_W+1  words written this session.

## Operation
- Mnemonic codes and their encodings:
  - R-type, funct value in brackets: 0 ADD(100000), 1 SUB(100010), 2 AND(100100), 3 OR(100101), 4 XOR(100110), 5 NOR(100111), 6 ADDU(100001), 7 SUBU(100011), 8 SLT(101010), 9 SLTU(101011), 10 SRL(000010), 11 SLL(000000).
  - I-type, opcode in brackets: 12 ADDI(001000), 13 ADDIU(001001), 14 ANDI(001100), 15 ORI(001101), 16 XORI(001110), 17 SLTI(001010), 18 SLTIU(001011), 19 LW(100011), 20 SW(101011), 21 BEQ(000100), 22 BNE(000101).
  - J-type: 23 J(000010), 24 JAL(000011).
  - Codes 25–31 are illegal.
- Field packing:
  - R-type: `{6'b0, rs, rt, rd, shamt, funct}`. shamt is forced to 0 except for SLL/SRL; rs is forced to 0 for SLL/SRL.
  - I-type: `{opcode, rs, rt, imm}`.
  - J-type: `{opcode, target}`.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: on `start`, clear pointer, count and both error flags; go to ACCEPT.
  - ACCEPT: `req_ready`=1. On a handshake with a legal op, register the encoded word and go to WRITE.
  - ACCEPT, illegal op: the handshake completes, nothing is written, and `err_illegal` is set. Go to DONE if `req_last`, otherwise stay in ACCEPT.
  - WRITE: `imem_we`=1 with `imem_addr`=pointer, then increment pointer and count.
    - If the registered `last` is set, go to DONE.
    - Else if pointer was `IMEM_DEPTH-1`, set `err_full` and go to DONE.
    - Otherwise go to ACCEPT.
  - DONE: `done`=1 for one cycle, then IDLE.
- `busy` is 1 in ACCEPT, WRITE and DONE.
- Error flags and `instr_count` hold their values through IDLE until the next `start`.

## Timing
- Reset values: state IDLE. All outputs 0: `req_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `busy`, `done`, both error flags, `instr_count`.
- Handshake at edge N means the write happens in cycle N+1.
- `req_ready` is 0 in cycle N+1 and returns to 1 in N+2.
- Peak throughput is one instruction per 2 cycles.
- `done` is asserted in the cycle after the final write, or in the cycle after an illegal request that carried `req_last`.
- `start` while busy is ignored.
- `req_valid` in IDLE or DONE is not accepted; `req_ready`=0 there.
- Fill boundary: a write to address `IMEM_DEPTH-1` with `last`=1 is a normal end and `err_full` stays 0.
- Reset asserted mid-session: return to IDLE at that edge, abort any pending write, clear all outputs.

## Structure
- Shared package `mips_pkg` holds:
  - the mnemonic code enum `op_e`;
  - opcode and funct localparams, also used by the control unit;
  - the instruction-format field widths.
- Sub-module `instr_pack`: purely combinational; takes (op, fields) and produces (word, illegal). The FSM, pointer and flags live in `instr_encoder`.

## Test plan
- ADD rs=1 rt=2 rd=3 with `last` → one write of 0x00221820 at addr 0, `done` pulse, `instr_count`=1.
- Stream ADDI rs=0 rt=8 imm=5; LW rs=8 rt=9 imm=4; J target=0x10 (last) → words 0x20080005, 0x8D090004, 0x08000010 at addrs 0–2, with `req_ready` low in the cycle after each handshake.
- SLL rs=7 rt=2 rd=4 shamt=3 → 0x000220C0 (rs forced 0). ADD with shamt=5, rs=rt=rd=0 → 0x00000020.
- op=27, then ADD rs=1 rt=2 rd=3 (last) → `err_illegal`=1, single write at addr 0, `instr_count`=1.
- `IMEM_DEPTH`=4, five requests without `last` → addrs 0–3 written, `err_full`=1 and `done` after the 4th write, 5th request never accepted.
- `rst_n` low in WRITE, 2nd request of a session → no write that cycle, all outputs 0 the next cycle; a fresh `start` writes from addr 0.
